// File: rtl/np_mem.sv
// -----------------------------------------------------------------------------
// np_mem : memory responder and program-load sequencer for the np RISC core.
//
// The module is the slave end of both core memory buses. Each bus is backed by
// a synchronous-read SRAM with one-cycle read latency. A valid/ready loader
// fills instruction memory while cpu_hold keeps the core in reset. The loader
// then releases the core and counts run cycles until the core raises halt.
//
// Build option:
//   NP_MEM_BYPASS_EN  defined   -> the data port is write-first (a write is
//                                  forwarded to dataIn on the next cycle)
//                     undefined -> the data port is read-first
//   The instruction port is read-first in both builds.
//
// Parameters:
//   WIDTH     data/instruction word width
//   ADDRSIZE  address width; each memory holds 1<<ADDRSIZE words
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   in_address        instruction address from core
//   in_wr             instruction write strobe from core (honoured in RUN only)
//   in_dataOut        instruction write data from core
//   in_dataIn         instruction read data to core (1-cycle latency)
//   address           data address from core
//   wr                data write strobe, 1 = write (honoured in RUN only)
//   dataOut           data write data from core
//   dataIn            data read data to core (1-cycle latency)
//   halt              core halt flag
//   ld_start          one-cycle pulse that begins a program load
//   ld_base           first instruction address to load
//   ld_count          number of words to load, 0..(1<<ADDRSIZE)
//   ld_valid/ld_ready loader word handshake
//   ld_data           loader word
//   cpu_hold          drives the core's reset; low only while running
//   run_cycles        cycles spent in RUN, saturating
//   state_o           FSM state: IDLE=0, LOAD=1, RUN=2, HALTED=3
//
// Loader handshake: a word transfers on a rising clock edge where
// ld_valid and ld_ready are both high. ld_ready depends only on the FSM
// state. The loader must hold ld_data stable while ld_valid is high and
// ld_ready is low. A beat whose ld_valid drops before ld_ready is never
// written. A beat presented on an edge where reset is high is not accepted.
// -----------------------------------------------------------------------------
module np_mem #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                reset,
  // instruction port
  input  logic [ADDRSIZE-1:0] in_address,
  input  logic                in_wr,
  input  logic [WIDTH-1:0]    in_dataOut,
  output logic [WIDTH-1:0]    in_dataIn,
  // data port
  input  logic [ADDRSIZE-1:0] address,
  input  logic                wr,
  input  logic [WIDTH-1:0]    dataOut,
  output logic [WIDTH-1:0]    dataIn,
  // core status
  input  logic                halt,
  // program loader
  input  logic                ld_start,
  input  logic [ADDRSIZE-1:0] ld_base,
  input  logic [ADDRSIZE:0]   ld_count,
  input  logic                ld_valid,
  input  logic [WIDTH-1:0]    ld_data,
  output logic                ld_ready,
  // control / observability
  output logic                cpu_hold,
  output logic [31:0]         run_cycles,
  output logic [1:0]          state_o
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] IDX_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Load bookkeeping: base and count are latched at ld_start. idx counts the
  // words that have transferred. count and idx are one bit wider than an
  // address, so a full-memory load (count = DEPTH) can be represented.
  logic [ADDRSIZE-1:0] base;
  logic [ADDRSIZE:0]   count;
  logic [ADDRSIZE:0]   idx;

  logic                start_take;
  logic                ld_fire;
  logic                ld_last;

  logic                imem_we;
  logic [ADDRSIZE-1:0] imem_wa;
  logic [WIDTH-1:0]    imem_wd;
  logic                dmem_we;

  logic [WIDTH-1:0]    imem [DEPTH];
  logic [WIDTH-1:0]    dmem [DEPTH];

  // ---------------------------------------------------------------------------
  // FSM: next-state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    start_take = 1'b0;
    ld_fire    = 1'b0;
    ld_last    = 1'b0;

    case (state)
      IDLE, HALTED: begin
        if (ld_start) begin
          start_take = 1'b1;
          // With nothing to load, skip LOAD so the FSM cannot wait forever
          // for a beat that will never arrive.
          state_next = (ld_count == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        // ld_ready is high throughout LOAD, so ld_valid alone completes a beat.
        ld_fire = ld_valid;
        ld_last = ld_valid && (idx == (count - IDX_ONE));
        // halt is not examined here, so a halt on the final beat is ignored.
        if (ld_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_next = HALTED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ld_ready = (state == LOAD);
  assign state_o  = state;

  // ---------------------------------------------------------------------------
  // FSM state and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      count      <= '0;
      idx        <= '0;
      cpu_hold   <= 1'b1;
      run_cycles <= '0;
    end else begin
      state <= state_next;

      // cpu_hold is registered from the current state. It therefore falls one
      // cycle after RUN is entered and rises one cycle after RUN is left.
      cpu_hold <= (state != RUN);

      if (start_take) begin
        base  <= ld_base;
        count <= ld_count;
        idx   <= '0;
      end else if (ld_fire) begin
        idx <= idx + IDX_ONE;
      end

      // Any accepted load request restarts the count. HALTED simply stops
      // incrementing, which leaves the final value visible.
      if (start_take) begin
        run_cycles <= '0;
      end else if ((state == RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
        run_cycles <= run_cycles + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction memory: loader owns the write port in LOAD, core in RUN only.
  // The write is gated by reset, so a beat coincident with reset is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_we = 1'b0;
    imem_wa = in_address;
    imem_wd = in_dataOut;
    if (!reset) begin
      if (ld_fire) begin
        imem_we = 1'b1;
        // Address arithmetic is ADDRSIZE bits wide, so the load wraps modulo
        // the memory size.
        imem_wa = base + idx[ADDRSIZE-1:0];
        imem_wd = ld_data;
      end else if ((state == RUN) && in_wr) begin
        imem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_wa] <= imem_wd;
    end
  end

  // Read-first: the non-blocking read sees the word from before this edge's write.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_dataIn <= '0;
    end else begin
      in_dataIn <= imem[in_address];
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: written only in RUN, read every cycle.
  // ---------------------------------------------------------------------------
  assign dmem_we = !reset && (state == RUN) && wr;

  always_ff @(posedge clk) begin
    if (dmem_we) begin
      dmem[address] <= dataOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataIn <= '0;
    end else begin
`ifdef NP_MEM_BYPASS_EN
      // Write-first: forward the word being written.
      if (dmem_we) begin
        dataIn <= dataOut;
      end else begin
        dataIn <= dmem[address];
      end
`else
      dataIn <= dmem[address];
`endif
    end
  end

endmodule

// File: tb/tb_np_mem.sv
// -----------------------------------------------------------------------------
// tb_np_mem : directed self-checking bench for np_mem.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_np_mem;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [ADDRSIZE-1:0] in_address;
  logic                in_wr;
  logic [WIDTH-1:0]    in_dataOut;
  logic [WIDTH-1:0]    in_dataIn;
  logic [ADDRSIZE-1:0] address;
  logic                wr;
  logic [WIDTH-1:0]    dataOut;
  logic [WIDTH-1:0]    dataIn;
  logic                halt;
  logic                ld_start;
  logic [ADDRSIZE-1:0] ld_base;
  logic [ADDRSIZE:0]   ld_count;
  logic                ld_valid;
  logic [WIDTH-1:0]    ld_data;
  logic                ld_ready;
  logic                cpu_hold;
  logic [31:0]         run_cycles;
  logic [1:0]          state_o;

  np_mem #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_address (in_address),
    .in_wr      (in_wr),
    .in_dataOut (in_dataOut),
    .in_dataIn  (in_dataIn),
    .address    (address),
    .wr         (wr),
    .dataOut    (dataOut),
    .dataIn     (dataIn),
    .halt       (halt),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .cpu_hold   (cpu_hold),
    .run_cycles (run_cycles),
    .state_o    (state_o)
  );

  localparam logic [31:0] S_IDLE = 32'd0, S_LOAD = 32'd1, S_RUN = 32'd2, S_HALTED = 32'd3;

`ifdef NP_MEM_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_EXP = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] SAME_CYCLE_EXP = 32'h1111_1111;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_address = '0; in_wr = 1'b0; in_dataOut = '0;
    address = '0; wr = 1'b0; dataOut = '0;
    halt = 1'b0; ld_start = 1'b0; ld_base = '0; ld_count = '0;
    ld_valid = 1'b0; ld_data = '0;

    // ---- reset values
    tick(); tick();
    check("rst_state", state_o, S_IDLE);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_in_dataIn", in_dataIn, 0);
    check("rst_dataIn", dataIn, 0);
    reset = 1'b0;

    // ---- load base=0 count=3, ld_valid held high
    ld_start = 1'b1; ld_base = 12'h000; ld_count = 13'd3;
    tick();
    ld_start = 1'b0;
    check("ld0_state", state_o, S_LOAD);
    check("ld0_ready_1", ld_ready, 1);
    check("ld0_hold", cpu_hold, 1);
    ld_valid = 1'b1; ld_data = 32'h3010_0000;
    tick();
    check("ld0_ready_2", ld_ready, 1);
    ld_data = 32'h4010_0000;
    tick();
    check("ld0_ready_3", ld_ready, 1);
    ld_data = 32'hB000_0000;
    tick();
    ld_valid = 1'b0;
    check("ld0_to_run", state_o, S_RUN);
    check("ld0_ready_off", ld_ready, 0);
    check("run_entry_hold", cpu_hold, 1);
    check("run_entry_cycles", run_cycles, 0);

    // ---- RUN: read back imem[0..2] (RUN cycles 1..3)
    in_address = 12'h000;
    tick();
    check("hold_falls", cpu_hold, 0);
    check("run_cycles_1", run_cycles, 1);
    check("imem0", in_dataIn, 32'h3010_0000);
    in_address = 12'h001;
    tick();
    check("imem1", in_dataIn, 32'h4010_0000);
    in_address = 12'h002;
    tick();
    check("imem2", in_dataIn, 32'hB000_0000);

    // ---- data port write/read (RUN cycles 4..6)
    address = 12'h010; wr = 1'b1; dataOut = 32'h1111_1111;
    tick();
    dataOut = 32'hDEAD_BEEF;
    tick();
    check("dmem_same_cycle", dataIn, SAME_CYCLE_EXP);
    wr = 1'b0;
    tick();
    check("dmem_readback", dataIn, 32'hDEAD_BEEF);

    // ---- instruction port read-first (RUN cycles 7..9)
    in_address = 12'h005; in_wr = 1'b1; in_dataOut = 32'hCAFE_0001;
    tick();
    in_dataOut = 32'hCAFE_0002;
    tick();
    check("imem_read_first", in_dataIn, 32'hCAFE_0001);
    in_wr = 1'b0;
    tick();
    check("imem_new_word", in_dataIn, 32'hCAFE_0002);
    check("run_cycles_9", run_cycles, 9);

    // ---- halt on RUN cycle 10
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halted_state", state_o, S_HALTED);
    check("halted_cycles", run_cycles, 10);

    // ---- HALTED: core writes dropped, counter held
    in_wr = 1'b1; in_dataOut = 32'hBAD0_0005; wr = 1'b1; dataOut = 32'h0000_0000;
    tick();
    in_wr = 1'b0; wr = 1'b0;
    check("halted_hold", cpu_hold, 1);
    check("halted_cycles_held", run_cycles, 10);
    check("halted_state_stays", state_o, S_HALTED);
    tick();
    check("halted_imem_drop", in_dataIn, 32'hCAFE_0002);
    check("halted_dmem_drop", dataIn, 32'hDEAD_BEEF);
    check("halted_cycles_held2", run_cycles, 10);

    // ---- wrapping load from HALTED: base=0xFFE count=4
    ld_start = 1'b1; ld_base = 12'hFFE; ld_count = 13'd4;
    tick();
    ld_start = 1'b0;
    check("wrap_state", state_o, S_LOAD);
    check("wrap_cycles_clear", run_cycles, 0);
    check("wrap_hold", cpu_hold, 1);
    // beat 0, with a core write in LOAD that must be ignored
    ld_valid = 1'b1; ld_data = 32'hA000_0000;
    in_wr = 1'b1; in_address = 12'h005; in_dataOut = 32'hBAD0_0006;
    tick();
    in_wr = 1'b0;
    // a bubble: ld_valid low, data not to be written
    ld_valid = 1'b0; ld_data = 32'h5555_5555;
    tick();
    check("wrap_bubble_state", state_o, S_LOAD);
    check("wrap_bubble_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_data = 32'hA000_0001;
    tick();
    ld_data = 32'hA000_0002;
    tick();
    // final beat coincides with halt: halt is ignored
    ld_data = 32'hA000_0003; halt = 1'b1;
    tick();
    halt = 1'b0; ld_valid = 1'b0;
    check("wrap_halt_ignored", state_o, S_RUN);
    in_address = 12'hFFE;
    tick();
    check("wrap_ffe", in_dataIn, 32'hA000_0000);
    in_address = 12'hFFF;
    tick();
    check("wrap_fff", in_dataIn, 32'hA000_0001);
    in_address = 12'h000;
    tick();
    check("wrap_000", in_dataIn, 32'hA000_0002);
    in_address = 12'h001;
    tick();
    check("wrap_001", in_dataIn, 32'hA000_0003);
    in_address = 12'h005;
    tick();
    check("load_ignores_in_wr", in_dataIn, 32'hCAFE_0002);

    // ---- count=0 from IDLE goes straight to RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_state", state_o, S_IDLE);
    check("rst2_hold", cpu_hold, 1);
    ld_start = 1'b1; ld_base = 12'h123; ld_count = 13'd0;
    tick();
    ld_start = 1'b0;
    check("cnt0_state", state_o, S_RUN);
    check("cnt0_ready", ld_ready, 0);
    tick();
    check("cnt0_ready_later", ld_ready, 0);
    check("cnt0_hold", cpu_hold, 0);

    // ---- ld_start ignored in RUN
    ld_start = 1'b1; ld_count = 13'd3;
    tick();
    ld_start = 1'b0;
    check("run_ignores_start", state_o, S_RUN);
    check("run_ignores_start_rdy", ld_ready, 0);

    // ---- preload 0x100..0x102, then abort a 5-word reload after 2 beats
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_start = 1'b1; ld_base = 12'h100; ld_count = 13'd3;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h0000_0F00;
    tick();
    ld_data = 32'h0000_0F01;
    tick();
    ld_data = 32'h0000_0F02;
    tick();
    ld_valid = 1'b0;
    check("pre_state", state_o, S_RUN);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_start = 1'b1; ld_base = 12'h100; ld_count = 13'd5;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h0000_0E00;
    tick();
    ld_data = 32'h0000_0E01;
    tick();
    ld_data = 32'h0000_0E02; reset = 1'b1;
    tick();
    reset = 1'b0; ld_valid = 1'b0;
    check("abort_state", state_o, S_IDLE);
    check("abort_ready", ld_ready, 0);
    check("abort_cycles", run_cycles, 0);
    in_address = 12'h100;
    tick();
    check("abort_imem100", in_dataIn, 32'h0000_0E00);
    in_address = 12'h101;
    tick();
    check("abort_imem101", in_dataIn, 32'h0000_0E01);
    in_address = 12'h102;
    tick();
    check("abort_imem102", in_dataIn, 32'h0000_0F02);
    check("idle_stays", state_o, S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/np_mem.md
# np_mem

Memory responder and program-load sequencer for the non-pipelined `np` RISC core. It is the slave end of both core memory buses: the instruction port (`in_*`) and the data port (`wr`/`address`/`dataIn`/`dataOut`). Each bus gets synchronous-read SRAM with one-cycle latency, which matches the core's FET/EXE/WB timing. A valid/ready loader fills instruction memory while `cpu_hold` keeps the core in reset, then releases it and counts run cycles until `halt`.

## Interface
- `WIDTH`, 32, data/instruction word width
- `ADDRSIZE`, 12, address width; each memory holds 1<<ADDRSIZE words
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `in_address`  in  ADDRSIZE  instruction address from core
- `in_wr`  in  1  instruction write strobe from core
- `in_dataOut`  in  WIDTH  instruction write data from core
- `in_dataIn`  out  WIDTH  instruction read data to core
- `address`  in  ADDRSIZE  data address from core
- `wr`  in  1  1 = write, 0 = read
- `dataOut`  in  WIDTH  data write data from core
- `dataIn`  out  WIDTH  data read data to core
- `halt`  in  1  core halt flag
- `ld_start`  in  1  one-cycle pulse that begins a program load
- `ld_base`  in  ADDRSIZE  first instruction address to load
- `ld_count`  in  ADDRSIZE+1  number of words, 0..4096
- `ld_valid`  in  1  loader word valid
- `ld_data`  in  WIDTH  loader word
- `ld_ready`  out  1  loader word accepted
- `cpu_hold`  out  1  drives the core's `reset`
- `run_cycles`  out  32  cycles spent in RUN, saturating
- `state_o`  out  2  IDLE=0, LOAD=1, RUN=2, HALTED=3

## Operation
- FSM states:
  - IDLE: `ld_start` -> LOAD, latching base/count and clearing the index. If `ld_count`=0, go straight to RUN.
  - LOAD: a word transfers when `ld_valid & ld_ready`. It writes imem[(base+idx) mod 2^ADDRSIZE], then idx++. The cycle the last word transfers -> RUN.
  - RUN: `halt`=1 -> HALTED.
  - HALTED: `ld_start` -> LOAD. No other exit except reset.
- `ld_start` is ignored in LOAD and RUN.
- `ld_ready` = 1 only in LOAD; it is combinational from state.
- `cpu_hold` = 1 in IDLE, LOAD and HALTED, and 0 only in RUN. It is registered, so it deasserts the cycle after RUN is entered.
- Instruction memory:
  - In LOAD the loader owns the write port and `in_wr` is ignored.
  - In RUN, `in_wr`=1 writes `in_dataOut` to `in_address`.
  - In all other states, core writes are dropped.
- Data memory: `wr`=1 writes `dataOut` to `address` in RUN only. Reads happen every cycle in every state.
- `run_cycles`:
  - increments each RUN cycle and saturates at 0xFFFFFFFF;
  - clears on entry to LOAD;
  - holds in HALTED.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `in_dataIn`=0, `dataIn`=0, `ld_ready`=0, `cpu_hold`=1, `run_cycles`=0, `state_o`=IDLE.
- Read latency is 1 cycle. An address sampled at posedge N appears on `in_dataIn`/`dataIn` after posedge N, stable for the core's next state.
- Writes take effect at the sampling edge.
- Instruction port is read-first: a read of the address being written returns the old word.
- Address wrap: load index past 2^ADDRSIZE-1 wraps to 0.
- Reset mid-LOAD aborts the load and returns to IDLE. Words already written remain.
- `halt` and the final loader beat in the same cycle: the FSM is in LOAD, so `halt` is ignored and the next state is RUN.
- A `ld_valid` beat that drops without `ld_ready` is not written. The loader must hold `ld_data` until the handshake completes.

## Configuration
- Macro: `NP_MEM_BYPASS_EN`.
- Defined: the data port forwards writes. When `wr`=1, the next-cycle `dataIn` equals the `dataOut` just written (write-first).
- Undefined: the data port is read-first and `dataIn` returns the pre-write word.
- The instruction port is read-first in both builds.

## Test plan
- Reset, then `ld_start` with base=0, count=3 and words 0x3010_0000, 0x4010_0000, 0xB000_0000 with `ld_valid` constant -> `ld_ready` high for exactly 3 cycles; imem[0..2] match; `cpu_hold` falls the cycle after RUN.
- Load base=0xFFE, count=4 -> words land at 0xFFE, 0xFFF, 0x000, 0x001.
- In RUN, write 0xDEADBEEF to address 0x010, then read 0x010 -> 0xDEADBEEF one cycle later. A same-cycle read returns the new value with `NP_MEM_BYPASS_EN` and the old value without it.
- `ld_count`=0 -> IDLE->RUN directly; `ld_ready` never asserts.
- RUN for 10 cycles, then `halt`=1 -> HALTED, `run_cycles`=10 held, `cpu_hold`=1. A following `ld_start` clears `run_cycles` to 0.
- Reset asserted after 2 of 5 load beats -> IDLE, `ld_ready`=0, imem[base], imem[base+1] written, imem[base+2] unchanged.
